// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and the default data-memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 1024;

  // req_size encodings
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering for the load/store unit. Purely combinational.
// Given the word read from memory, it produces the sign/zero-extended load
// value for the addressed lane and the merged word for a sub-word store.
// A half access only looks at offset_i[1]; a word access ignores the offset.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Per-byte-lane split of the read word and the store merge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE_IDX = 2'(gi);
    localparam logic       LANE_HI  = LANE_IDX[1];

    logic byte_hit;
    logic half_hit;

    assign lane[gi]  = word_i[8*gi +: 8];
    assign byte_hit  = (offset_i == LANE_IDX);
    assign half_hit  = (offset_i[1] == LANE_HI);

    // Half stores feed byte gi from wdata byte (gi % 2) of the low half.
    assign merge_o[8*gi +: 8] =
        (size_i == SZ_BYTE) ? (byte_hit ? wdata_i[7:0] : lane[gi]) :
        (size_i == SZ_HALF) ? (half_hit ? wdata_i[8*(gi%2) +: 8] : lane[gi]) :
                              wdata_i[8*gi +: 8];
  end

  assign byte_val = lane[offset_i];
  assign half_val = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // Extend the selected lane: replicate its MSB unless zero-extension asked.
  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{byte_val[7]  & ~unsigned_i}}, byte_val};
      SZ_HALF: load_o = {{16{half_val[15] & ~unsigned_i}}, half_val};
      default: load_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-addressed data-memory port.
// Accepts one request at a time, performs byte/half/word loads with
// extension, does sub-word stores as read-modify-write, and returns one
// response per request.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses return an error instead of being aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-2:0] MEM_WORDS_L = (ADDR_W-1)'(MEM_WORDS);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [ADDR_W-2:0] req_word_idx;
  logic              range_err;
  logic              size_err;
  logic              misalign_err;
  logic              req_err;
  logic              word_store;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;

  // Request classification, done on the live request while IDLE.
  assign req_word_idx = {1'b0, req_addr[ADDR_W-1:2]};
  assign range_err    = (req_word_idx >= MEM_WORDS_L);
  assign size_err     = (req_size == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_err = 1'b0;
`endif
  assign req_err      = range_err | size_err | misalign_err;

  assign word_store = we_q && (size_q == SZ_WORD);
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  lsu_lane_align u_lane_align (
    .word_i     (mem_rdata),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  // Next-state and register-update logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr;
          size_d       = req_size;
          uns_d        = req_unsigned;
          we_d         = req_we;
          wdata_d      = req_wdata;
          resp_rdata_d = 32'h0;
          resp_err_d   = req_err;
          state_d      = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          resp_rdata_d = load_val;
          state_d      = RESP;
        end else if (word_store) begin
          state_d = RESP;
        end else begin
          merged_d = merge_val;
          state_d  = MERGE_WR;
        end
      end
      MERGE_WR: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory port drive; enables are masked by rst so an aborted RMW never writes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_addr = word_addr;
        if (word_store) begin
          mem_we    = ~rst;
          mem_wdata = wdata_q;
        end else begin
          mem_re = ~rst;
        end
      end
      MERGE_WR: begin
        mem_addr  = word_addr;
        mem_we    = ~rst;
        mem_wdata = merged_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural data memory with a preload port and activity counters.
  logic [31:0] mem [1024];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_data = 32'h0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          we_cyc = -1;

  assign mem_rdata = mem_re ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
      we_cyc <= cyc;
    end
    if (mem_re) re_cnt <= re_cnt + 1;
  end

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] b32(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pre_en   = 1'b1;
    pre_idx  = 10'(idx);
    pre_data = data;
    @(posedge clk); #1;
    pre_en   = 1'b0;
  endtask

  // Issue one request, check latency and response against the scoreboard,
  // optionally hold off resp_ready for 'hold' cycles, then complete it.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                        input int hold, output int acc_cyc);
    exp_t e;
    int   lat;
    sb_q.push_back({exp_e, exp_d});
    chk({tag, "_req_ready"}, b32(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk); #1;
    acc_cyc   = cyc - 1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_resp_valid"}, b32(resp_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e.data);
    chk({tag, "_err"}, b32(resp_err), b32(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, b32(resp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, e.data);
      chk({tag, "_hold_err"}, b32(resp_err), b32(e.err));
      chk({tag, "_hold_req_ready"}, b32(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int we0;
    int re0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state
    chk("rst_req_ready", b32(req_ready), 32'd1);
    chk("rst_resp_valid", b32(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", b32(resp_err), 32'd0);
    chk("rst_mem_we", b32(mem_we), 32'd0);
    chk("rst_mem_re", b32(mem_re), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // Word round trip
    do_req("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, acc);
    chk("sw_10_mem", mem[4], 32'hDEADBEEF);
    do_req("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, acc);

    // Byte store read-modify-write
    preload(4, 32'h11223344);
    we0 = we_cnt;
    do_req("sb_12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3, 0, acc);
    chk("sb_12_mem", mem[4], 32'h11AA3344);
    chk("sb_12_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("sb_12_we_cycle", 32'(we_cyc), 32'(acc + 2));

    // Extension
    preload(8, 32'h80FF7F01);
    do_req("lb_22",  1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0, acc);
    do_req("lbu_22", 1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 32'h000000FF, 1'b0, 2, 0, acc);
    do_req("lh_22",  1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, acc);
    do_req("lhu_20", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2, 0, acc);
    do_req("lb_20",  1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 32'h00000001, 1'b0, 2, 0, acc);
    do_req("lb_23",  1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, acc);
    do_req("lbu_21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h0000007F, 1'b0, 2, 0, acc);

    // Half store merge into the upper half
    do_req("sh_22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, 3, 0, acc);
    chk("sh_22_mem", mem[8], 32'h12347F01);

    // Range error with backpressure, reserved size, last valid word
    re0 = re_cnt;
    we0 = we_cnt;
    do_req("lw_1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 5, acc);
    do_req("sz3_00", 1'b1, 2'd3, 1'b0, 32'h0, 32'h55, 32'h0, 1'b1, 1, 0, acc);
    chk("err_no_re", 32'(re_cnt - re0), 32'd0);
    chk("err_no_we", 32'(we_cnt - we0), 32'd0);
    preload(1023, 32'h12345678);
    do_req("lw_ffc", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 32'h12345678, 1'b0, 2, 0, acc);

    // Reset in the write phase of a half-store RMW
    preload(12, 32'hCAFEF00D);
    we0 = we_cnt;
    chk("rmw_rst_req_ready", b32(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr  = 32'h32; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_rst_merge_we", b32(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw_rst_we_masked", b32(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmw_rst_resp_valid", b32(resp_valid), 32'd0);
    chk("rmw_rst_req_ready", b32(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rmw_rst_mem", mem[12], 32'hCAFEF00D);
    chk("rmw_rst_no_we", 32'(we_cnt - we0), 32'd0);

    // Misaligned accesses
    re0 = re_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw_13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, acc);
    do_req("lh_21", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0, acc);
    chk("misalign_no_re", 32'(re_cnt - re0), 32'd0);
`else
    do_req("lw_13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h11AA3344, 1'b0, 2, 0, acc);
    do_req("lh_21", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h00007F01, 1'b0, 2, 0, acc);
    chk("misalign_re", 32'(re_cnt - re0), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
